// File: rtl/usb_consts_pkg.sv
// Shared USB full-speed constants: PID encodings, PID classes and the CRC16 helper
// used by both the transmit framer and the receive checker.
package usb_consts_pkg;

  typedef enum logic [3:0] {
    UsbPidOut   = 4'h1,
    UsbPidAck   = 4'h2,
    UsbPidData0 = 4'h3,
    UsbPidSof   = 4'h5,
    UsbPidIn    = 4'h9,
    UsbPidNak   = 4'hA,
    UsbPidData1 = 4'hB,
    UsbPidSetup = 4'hD,
    UsbPidStall = 4'hE
  } usb_pid_e;

  // Class is carried in pid[1:0].
  typedef enum logic [1:0] {
    UsbPidTypeSpecial   = 2'b00,
    UsbPidTypeToken     = 2'b01,
    UsbPidTypeHandshake = 2'b10,
    UsbPidTypeData      = 2'b11
  } usb_pid_type_e;

  localparam logic [15:0] UsbCrc16Init     = 16'hFFFF;
  localparam logic [15:0] UsbCrc16PolyRefl = 16'hA001;
  // Good-packet remainder in x^15..x^0 order. The reflected accumulator below
  // holds the bit-reversed value (16'hB001) after a clean payload+CRC.
  localparam logic [15:0] UsbCrc16Residual = 16'h800D;

  // Byte-wide CRC16 update, data bits consumed LSB first (line order).
  function automatic logic [15:0] usb_crc16_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ UsbCrc16PolyRefl;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_fs_tx_crc16.sv
// Registered CRC16 accumulator; clear wins over update.
module usb_fs_tx_crc16
  import usb_consts_pkg::*;
(
  input  logic        clk_48mhz_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        update_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] r_crc;

  // Accumulate one payload byte per update, restart on clear.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni)       r_crc <= UsbCrc16Init;
    else if (clear_i)  r_crc <= UsbCrc16Init;
    else if (update_i) r_crc <= usb_crc16_byte(r_crc, data_i);
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/usb_fs_tx_pkt_framer.sv
// Transmit packet framer: PID byte, optional payload pulled from the protocol
// engine, then the complemented CRC16, handed to the serializer byte by byte.
//
//   state     | meaning
//   StIdle    | waiting for a start strobe
//   StPid     | presenting the PID byte
//   StFetch   | deciding: fetch next payload byte or close with CRC
//   StData    | presenting a payload byte
//   StWait    | letting the data source settle after a get
//   StCrcLo   | presenting ~crc[7:0]
//   StCrcHi   | presenting ~crc[15:8], last byte of packet
//   StWaitEop | packet handed off, waiting for the line EOP
module usb_fs_tx_pkt_framer
  import usb_consts_pkg::*;
#(
  parameter int MaxPktSizeByte = 64,
  parameter int DataLatency    = 2
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_ni,
  input  logic       link_reset_i,
  input  logic       tx_pkt_start_i,
  input  logic [3:0] tx_pid_i,
  output logic       tx_pkt_end_o,
  input  logic       tx_data_avail_i,
  output logic       tx_data_get_o,
  input  logic [7:0] tx_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       byte_last_o,
  input  logic       line_eop_i,
  output logic       busy_o,
  output logic       err_overlength_o
);

  localparam int CntW = $clog2(MaxPktSizeByte + 1);
  localparam int LatW = (DataLatency > 1) ? $clog2(DataLatency) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxPktSizeByte);
  // Loaded at the fetch edge; reaching zero in StWait means the source has
  // had DataLatency cycles since the get pulse by the next StFetch.
  localparam logic [LatW-1:0] LatLoad = LatW'(DataLatency - 1);

  typedef enum logic [2:0] {
    StIdle, StPid, StFetch, StData, StWait, StCrcLo, StCrcHi, StWaitEop
  } state_e;

  state_e          r_state;
  logic [3:0]      r_pid;
  logic [CntW-1:0] r_cnt;
  logic [LatW-1:0] r_lat;
  logic [7:0]      r_byte;
  logic            r_valid;
  logic            r_last;
  logic            r_get;
  logic            r_err;
  logic            r_end;

  logic            w_xfer;
  logic            w_start;
  logic            w_fetch;
  logic            w_pid_data;
  logic [15:0]     w_crc;

  assign w_xfer     = r_valid & byte_ready_i;
  assign w_start    = (r_state == StIdle) & tx_pkt_start_i & ~link_reset_i;
  assign w_fetch    = (r_state == StFetch) & tx_data_avail_i & (r_cnt < MaxCnt);
  assign w_pid_data = (usb_pid_type_e'(r_pid[1:0]) == UsbPidTypeData);

  usb_fs_tx_crc16 u_crc (
    .clk_48mhz_i (clk_48mhz_i),
    .rst_ni      (rst_ni),
    .clear_i     (link_reset_i | w_start),
    .update_i    (w_fetch & ~link_reset_i),
    .data_i      (tx_data_i),
    .crc_o       (w_crc)
  );

  // Packet sequencing with registered handshake and pulse outputs.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_pid   <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_get   <= 1'b0;
      r_err   <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_get <= 1'b0;
      r_err <= 1'b0;
      r_end <= 1'b0;
      if (r_lat != '0) r_lat <= r_lat - LatW'(1);
      if (link_reset_i) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_lat   <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: if (tx_pkt_start_i) begin
            r_pid   <= tx_pid_i;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= (usb_pid_type_e'(tx_pid_i[1:0]) != UsbPidTypeData);
            r_state <= StPid;
          end
          StPid: if (w_xfer) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= w_pid_data ? StFetch : StWaitEop;
          end
          StFetch: begin
            r_valid <= 1'b1;
            if (w_fetch) begin
              r_get   <= 1'b1;
              r_byte  <= tx_data_i;
              r_cnt   <= r_cnt + CntW'(1);
              r_lat   <= LatLoad;
              r_state <= StData;
            end else begin
              // Still-available data here can only mean the size cap was hit.
              r_err   <= tx_data_avail_i;
              r_byte  <= ~w_crc[7:0];
              r_state <= StCrcLo;
            end
          end
          StData: if (w_xfer) begin
            r_valid <= 1'b0;
            r_state <= StWait;
          end
          StWait: if (r_lat == '0) r_state <= StFetch;
          StCrcLo: if (w_xfer) begin
            r_byte  <= ~w_crc[15:8];
            r_last  <= 1'b1;
            r_state <= StCrcHi;
          end
          StCrcHi: if (w_xfer) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= StWaitEop;
          end
          StWaitEop: if (line_eop_i) begin
            r_end   <= 1'b1;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign byte_o           = (r_state == StPid) ? {~r_pid, r_pid} : r_byte;
  assign byte_valid_o     = r_valid;
  assign byte_last_o      = r_last;
  assign tx_data_get_o    = r_get;
  assign err_overlength_o = r_err;
  assign tx_pkt_end_o     = r_end;
  assign busy_o           = (r_state != StIdle);

endmodule

// File: tb/tb_usb_fs_tx_pkt_framer.sv
// Directed bench for the transmit packet framer with a packet-level byte model.
module tb_usb_fs_tx_pkt_framer;

  localparam int MaxPkt = 64;
  localparam int Lat    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_reset_i, tx_pkt_start_i, tx_data_avail_i, byte_ready_i, line_eop_i;
  logic [3:0] tx_pid_i;
  logic [7:0] tx_data_i;
  logic       tx_pkt_end_o, tx_data_get_o, byte_valid_o, byte_last_o, busy_o, err_overlength_o;
  logic [7:0] byte_o;

  always #10 clk = ~clk;

  usb_fs_tx_pkt_framer #(.MaxPktSizeByte(MaxPkt), .DataLatency(Lat)) dut (
    .clk_48mhz_i      (clk),
    .rst_ni           (rst_n),
    .link_reset_i     (link_reset_i),
    .tx_pkt_start_i   (tx_pkt_start_i),
    .tx_pid_i         (tx_pid_i),
    .tx_pkt_end_o     (tx_pkt_end_o),
    .tx_data_avail_i  (tx_data_avail_i),
    .tx_data_get_o    (tx_data_get_o),
    .tx_data_i        (tx_data_i),
    .byte_o           (byte_o),
    .byte_valid_o     (byte_valid_o),
    .byte_ready_i     (byte_ready_i),
    .byte_last_o      (byte_last_o),
    .line_eop_i       (line_eop_i),
    .busy_o           (busy_o),
    .err_overlength_o (err_overlength_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference CRC16: reflected poly 0xA001, bits LSB first.
  function automatic logic [15:0] tb_crc(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) c = ((c[0] ^ d[i]) ? 16'hA001 : 16'h0000) ^ (c >> 1);
    return c;
  endfunction

  // ---------------- payload source ----------------
  logic [7:0] src_mem [0:79];
  int src_len, src_idx, src_wait;
  bit src_inf;

  function automatic logic [7:0] src_byte(input int i);
    if (src_inf) return 8'(i) ^ 8'h5A;
    return src_mem[i];
  endfunction

  task automatic src_present();
    tx_data_avail_i = src_inf || (src_idx < src_len);
    tx_data_i       = tx_data_avail_i ? src_byte(src_idx) : 8'hEE;
  endtask

  task automatic src_load(input int len, input bit inf);
    src_idx = 0; src_len = len; src_inf = inf; src_wait = 0;
    src_present();
  endtask

  // Next byte appears DataLatency cycles after the get; garbage in between.
  initial begin
    src_idx = 0; src_len = 0; src_inf = 0; src_wait = 0;
    forever begin
      @(posedge clk); #2;
      if (tx_data_get_o) begin
        src_idx++;
        tx_data_avail_i = 1'b0;
        tx_data_i = 8'hEE;
        src_wait = Lat;
      end else if (src_wait > 0) begin
        src_wait--;
        if (src_wait == 0) src_present();
      end
    end
  end

  // ---------------- ready throttle ----------------
  bit thr_en = 0;
  initial forever begin
    @(posedge clk); #1;
    if (thr_en) byte_ready_i = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / compare ----------------
  logic [8:0] exp_q[$];
  logic [7:0] rx_log[$];
  logic [8:0] e_front;
  int n_gets, n_err, n_end, last_get, m_gets, m_err;
  bit prev_hold = 0;
  logic [7:0] prev_byte;
  logic prev_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold)
        chk("hold", 32'({byte_valid_o, byte_last_o, byte_o}), 32'({1'b1, prev_last, prev_byte}));
      if (byte_valid_o && byte_ready_i) begin
        rx_log.push_back(byte_o);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_byte: got %0h, want no byte", byte_o);
        end else begin
          e_front = exp_q.pop_front();
          chk("byte", 32'({byte_last_o, byte_o}), 32'(e_front));
        end
      end
      if (tx_data_get_o) begin
        n_gets++;
        if (last_get >= 0) chk("get_gap_ok", 32'((cyc - last_get) >= Lat + 1), 32'(1));
        last_get = cyc;
      end
      if (err_overlength_o) n_err++;
      if (tx_pkt_end_o) n_end++;
      prev_hold = byte_valid_o && !byte_ready_i && !link_reset_i;
      prev_byte = byte_o;
      prev_last = byte_last_o;
    end
  end

  // ---------------- packet model ----------------
  task automatic build_exp(input logic [3:0] pid);
    logic [15:0] crc;
    logic [7:0] b;
    bit is_data;
    int n;
    exp_q.delete(); rx_log.delete();
    n_gets = 0; n_err = 0; n_end = 0; last_get = -1;
    is_data = (pid[1:0] == 2'b11);
    exp_q.push_back({!is_data, ~pid, pid});
    m_gets = 0; m_err = 0;
    if (is_data) begin
      n = src_inf ? MaxPkt : ((src_len > MaxPkt) ? MaxPkt : src_len);
      m_err = (src_inf || src_len > MaxPkt) ? 1 : 0;
      m_gets = n;
      crc = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
        b = src_byte(i);
        crc = tb_crc(crc, b);
        exp_q.push_back({1'b0, b});
      end
      exp_q.push_back({1'b0, ~crc[7:0]});
      exp_q.push_back({1'b1, ~crc[15:8]});
    end
  endtask

  task automatic start_pkt(input logic [3:0] pid);
    @(posedge clk); #1;
    tx_pid_i = pid; tx_pkt_start_i = 1'b1;
    @(posedge clk); #1;
    tx_pkt_start_i = 1'b0; tx_pid_i = 4'h0;
  endtask

  task automatic end_pkt(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(posedge clk); k++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: %0d bytes still expected", name, exp_q.size());
      exp_q.delete();
    end
    #1 line_eop_i = 1'b1;
    @(posedge clk); #1 line_eop_i = 1'b0;
    @(negedge clk);
    chk({name, "_pkt_end"}, 32'(tx_pkt_end_o), 32'(1));
    chk({name, "_busy_after"}, 32'(busy_o), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_end_count"}, 32'(n_end), 32'(1));
    chk({name, "_gets"}, 32'(n_gets), 32'(m_gets));
    chk({name, "_overlength"}, 32'(n_err), 32'(m_err));
    thr_en = 0;
    byte_ready_i = 1'b1;
  endtask

  task automatic run_pkt(input string name, input logic [3:0] pid, input bit throttle);
    build_exp(pid);
    thr_en = throttle;
    start_pkt(pid);
    end_pkt(name);
  endtask

  function automatic logic [15:0] residual_of_log();
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    for (int i = 1; i < rx_log.size(); i++) c = tb_crc(c, rx_log[i]);
    r = {<<{c}};
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int k, g;
    rst_n = 1'b0; link_reset_i = 1'b0; tx_pkt_start_i = 1'b0; tx_pid_i = 4'h0;
    tx_data_avail_i = 1'b0; tx_data_i = 8'h00; byte_ready_i = 1'b1; line_eop_i = 1'b0;
    n_gets = 0; n_err = 0; n_end = 0; last_get = -1;
    for (int i = 0; i < 80; i++) src_mem[i] = 8'(i * 37 + 11);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({byte_o, byte_valid_o, byte_last_o, tx_data_get_o,
                              tx_pkt_end_o, busy_o, err_overlength_o}), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({byte_valid_o, busy_o}), 32'(0));

    // EOP while idle is ignored.
    @(posedge clk); #1 line_eop_i = 1'b1;
    @(posedge clk); #1 line_eop_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("eop_idle_no_end", 32'({n_end[7:0], busy_o}), 32'(0));

    // ACK handshake.
    src_load(0, 0);
    run_pkt("ack", 4'h2, 0);
    chk("ack_len", 32'(rx_log.size()), 32'(1));
    if (rx_log.size() > 0) chk("ack_byte", 32'(rx_log[0]), 32'h00D2);

    // DATA1 zero-length.
    src_load(0, 0);
    run_pkt("zlp", 4'hB, 0);
    chk("zlp_len", 32'(rx_log.size()), 32'(3));
    if (rx_log.size() == 3) begin
      chk("zlp_pid", 32'(rx_log[0]), 32'h004B);
      chk("zlp_crc", 32'({rx_log[1], rx_log[2]}), 32'h0000);
    end

    // DATA0 00 01 02 03 with throttled ready.
    for (int i = 0; i < 4; i++) src_mem[i] = 8'(i);
    src_load(4, 0);
    run_pkt("data0", 4'h3, 1);
    chk("data0_len", 32'(rx_log.size()), 32'(7));
    if (rx_log.size() > 0) chk("data0_pid", 32'(rx_log[0]), 32'h00C3);
    chk("data0_residual", 32'(residual_of_log()), 32'h800D);

    // Exactly MaxPkt bytes: no truncation.
    for (int i = 0; i < 80; i++) src_mem[i] = 8'(i * 37 + 11);
    src_load(64, 0);
    run_pkt("full64", 4'hB, 0);
    chk("full64_len", 32'(rx_log.size()), 32'(67));
    chk("full64_residual", 32'(residual_of_log()), 32'h800D);

    // Overlength: data always available.
    src_load(0, 1);
    run_pkt("over", 4'h3, 0);
    chk("over_len", 32'(rx_log.size()), 32'(67));
    chk("over_residual", 32'(residual_of_log()), 32'h800D);

    // Abort mid-payload.
    src_load(8, 0);
    build_exp(4'h3);
    start_pkt(4'h3);
    k = 0;
    while (n_gets < 2 && k < 200) begin @(posedge clk); k++; end
    chk("abort_reached_payload", 32'(n_gets >= 2), 32'(1));
    #1 link_reset_i = 1'b1;
    @(posedge clk); #1 link_reset_i = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({byte_valid_o, busy_o}), 32'(0));
    exp_q.delete();
    g = n_gets;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_get", 32'(n_gets), 32'(g));
    chk("abort_no_end", 32'(n_end), 32'(0));

    // Link reset beats a simultaneous start.
    @(posedge clk); #1 link_reset_i = 1'b1; tx_pkt_start_i = 1'b1; tx_pid_i = 4'h3;
    @(posedge clk); #1 link_reset_i = 1'b0; tx_pkt_start_i = 1'b0; tx_pid_i = 4'h0;
    @(negedge clk);
    chk("reset_priority", 32'({byte_valid_o, busy_o}), 32'(0));

    // Next packet frames cleanly.
    src_mem[0] = 8'hA5; src_mem[1] = 8'h5A;
    src_load(2, 0);
    run_pkt("post_abort", 4'h3, 0);
    chk("post_abort_len", 32'(rx_log.size()), 32'(5));
    chk("post_abort_residual", 32'(residual_of_log()), 32'h800D);

    // Start while busy, with ready held low to park in the payload byte.
    for (int i = 0; i < 3; i++) src_mem[i] = 8'(8'hF0 + i);
    src_load(3, 0);
    byte_ready_i = 1'b0;
    build_exp(4'hB);
    start_pkt(4'hB);
    repeat (3) @(posedge clk);
    #1 byte_ready_i = 1'b1;
    @(posedge clk); #1 byte_ready_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_parked_gets", 32'({n_gets[7:0], busy_o, byte_valid_o}), 32'({8'd1, 1'b1, 1'b1}));
    tx_pkt_start_i = 1'b1; tx_pid_i = 4'h2;
    @(posedge clk); #1 tx_pkt_start_i = 1'b0; tx_pid_i = 4'h0;
    repeat (3) @(posedge clk);
    #1 byte_ready_i = 1'b1;
    end_pkt("busy_start");
    chk("busy_start_len", 32'(rx_log.size()), 32'(6));
    if (rx_log.size() > 0) chk("busy_start_pid", 32'(rx_log[0]), 32'h004B);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_start_stays_idle", 32'({busy_o, byte_valid_o}), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
